cpu_ctrl_seq: RTL and testbench
===============================

# cpu_ctrl_seq

Multi-cycle fetch/execute sequencer for the 4-bit CPU. It fetches 8-bit instructions from instruction memory over a req/ack handshake and decodes the `lib_cpu::OPECODE` field. It then issues one-cycle write-enable, source-select and IP-update strobes to the register/ALU datapath that holds `REGS`. Invalid opcodes and fetch timeouts halt the core.

## Interface
Parameters:
- `FETCH_TIMEOUT`, default 15: max FETCH cycles without ack before halting; 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `run` in 1: level; continuous execution enable.
- `step` in 1: single-step pulse; used only with `CPU_CTRL_STEP_EN`.
- `ip` in 4: current IP from datapath.
- `cf` in 1: current carry flag from datapath.
- `imem_req` out 1: fetch request.
- `imem_addr` out 4: fetch address.
- `imem_ack` in 1: fetch done, data valid.
- `imem_data` in 8: instruction; [7:4] opcode, [3:0] immediate.
- `a_we`, `b_we`, `out_we`, `cf_we` out 1 each: datapath write strobes.
- `src_sel` out 2: ALU source, 0=A, 1=B, 2=IN, 3=ZERO.
- `imm` out 4: ALU addend.
- `ip_inc`, `ip_load` out 1 each: IP+1 or IP←imm.
- `retire` out 1: pulse, one instruction completed.
- `halted` out 1: sticky halt.
- `fetch_err` out 1: sticky, halt was caused by timeout.

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- IDLE→FETCH when `run`=1.
- FETCH:
  - drive `imem_req`=1 and `imem_addr`=`ip`.
  - On `imem_ack`, latch `imem_data` into IR and go to EXEC.
  - Wait counter increments each FETCH cycle without ack.
  - Counter reaching `FETCH_TIMEOUT` without ack → HALT, `fetch_err`=1.
- EXEC: decode IR[7:4], zero-extended to 8 bits, against OPECODE. Pulse strobes for one cycle, then FETCH if `run`=1, else IDLE.
- Decode, giving destination / src_sel / imm:
  - MOV_A_B: A / B / 0
  - MOV_B_A: B / A / 0
  - MOV_A_IMM: A / ZERO / IR
  - MOV_B_IMM: B / ZERO / IR
  - IN_A: A / IN / 0
  - IN_B: B / IN / 0
  - OUT_B: OUT / B / 0
  - OUT_IMM: OUT / ZERO / IR
  - ADD_A_IMM: A / A / IR
  - ADD_B_IMM: B / B / IR
  - JMP_IMM: none / ZERO / IR
  - JNC_IMM: none / ZERO / IR
- `cf_we`=1 for every valid opcode.
- IP update:
  - `ip_load`=1 for JMP_IMM, and for JNC_IMM when `cf`=0.
  - Otherwise `ip_inc`=1. They are never both high.
  - IP wraps 15→0 in the datapath; the controller does not special-case it.
- Opcode 12..15 (INVALID and above): no strobes, no IP change, no retire. Go to HALT, `halted`=1.
- HALT is absorbing; only `rst_n` exits.

## Timing
- Reset, async: state IDLE, IR=0, counter=0, every output 0.
- All outputs are registered-state decodes. Strobes are high only in EXEC.
- Ack may arrive in the first FETCH cycle, giving a minimum of 2 cycles per instruction: FETCH then EXEC.
- `imem_req` holds with a stable address until ack or timeout. Ack outside FETCH is ignored.
- Ack in the same cycle the counter hits the limit: ack wins, no error.
- `run` falling mid-FETCH or mid-EXEC: the current instruction completes, then IDLE.
- `retire` coincides with the EXEC cycle of each valid instruction.
- `rst_n` assertion mid-instruction aborts immediately. No partial strobes after reset.

## Configuration
- `CPU_CTRL_STEP_EN` defined:
  - In IDLE with `run`=0, a `step`=1 cycle starts FETCH.
  - After EXEC return to IDLE regardless of `step`.
  - `step` while `run`=1 or while not IDLE is ignored.
- Undefined: `step` is ignored and only `run` leaves IDLE.

## Structure
- Add to package `lib_cpu`:
  - `CTRL_SIG` packed struct: we bits, src_sel, imm, ip_inc, ip_load.
  - `CTRL_STATE` enum: IDLE, FETCH, EXEC, HALT.
  - `SRC_A`, `SRC_B`, `SRC_IN`, `SRC_ZERO` constants.
- Sub-module `cpu_decoder`: combinational IR+cf → `CTRL_SIG`, plus an invalid flag.
- Sequencer FSM, IR and timeout counter live in `cpu_ctrl_seq`.

## Test plan
- Reset, `run`=1, ROM `0x31` (MOV_B_IMM 1) with ack on cycle 1 → EXEC cycle: `b_we`=1, `src_sel`=3, `imm`=1, `ip_inc`=1, `retire`=1.
- `0xB5` (JNC_IMM 5): with `cf`=0 → `ip_load`=1, `imm`=5; with `cf`=1 → `ip_inc`=1, `ip_load`=0.
- Ack delayed 3 cycles on `0x8F` → `imem_req` high for 4 cycles, address stable, then `a_we`=1, `src_sel`=0, `imm`=15.
- No ack, `FETCH_TIMEOUT`=4 → HALT after 4 FETCH cycles, `fetch_err`=1, no strobes. Ack on exactly cycle 4 → normal EXEC.
- Opcode `0xC0` → `halted`=1, no strobes, `retire`=0. Stays halted with `run`=1 until `rst_n` pulse.
- With `CPU_CTRL_STEP_EN`, `run`=0: one `step` pulse → exactly one `retire`, then IDLE. `step` during FETCH is ignored.

Source files
------------

// File: rtl/cpu_ctrl_seq_pkg.sv
// lib_cpu: shared types for the 4-bit CPU controller.
//   OPECODE    - 8-bit opcode enumeration (instruction [7:4], zero-extended)
//   SRC_*      - ALU source-select encodings
//   CTRL_SIG   - one cycle's worth of datapath control strobes
//   CTRL_STATE - fetch/execute sequencer states
package lib_cpu;

  typedef enum logic [7:0] {
    MOV_A_B   = 8'd0,
    MOV_B_A   = 8'd1,
    MOV_A_IMM = 8'd2,
    MOV_B_IMM = 8'd3,
    IN_A      = 8'd4,
    IN_B      = 8'd5,
    OUT_B     = 8'd6,
    OUT_IMM   = 8'd7,
    ADD_A_IMM = 8'd8,
    ADD_B_IMM = 8'd9,
    JMP_IMM   = 8'd10,
    JNC_IMM   = 8'd11,
    INVALID   = 8'd12
  } OPECODE;

  localparam logic [1:0] SRC_A    = 2'd0;
  localparam logic [1:0] SRC_B    = 2'd1;
  localparam logic [1:0] SRC_IN   = 2'd2;
  localparam logic [1:0] SRC_ZERO = 2'd3;

  typedef struct packed {
    logic       a_we;
    logic       b_we;
    logic       out_we;
    logic       cf_we;
    logic [1:0] src_sel;
    logic [3:0] imm;
    logic       ip_inc;
    logic       ip_load;
  } CTRL_SIG;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } CTRL_STATE;

endpackage

// File: rtl/cpu_ctrl_seq_decoder.sv
// cpu_decoder: combinational instruction decoder.
//   ir      in  8 : instruction register, [7:4] opcode, [3:0] immediate
//   cf      in  1 : carry flag, selects the JNC_IMM branch
//   sig     out   : CTRL_SIG strobes for the EXEC cycle
//   invalid out 1 : opcode is INVALID or above
module cpu_decoder
  import lib_cpu::*;
(
  input  logic [7:0] ir,
  input  logic       cf,
  output CTRL_SIG    sig,
  output logic       invalid
);

  logic [7:0] opc;
  assign opc = {4'h0, ir[7:4]};

  always_comb begin
    sig         = '0;
    invalid     = 1'b0;
    sig.cf_we   = 1'b1;
    sig.ip_inc  = 1'b1;
    sig.src_sel = SRC_ZERO;
    case (opc)
      MOV_A_B:   begin sig.a_we   = 1'b1; sig.src_sel = SRC_B;    end
      MOV_B_A:   begin sig.b_we   = 1'b1; sig.src_sel = SRC_A;    end
      MOV_A_IMM: begin sig.a_we   = 1'b1; sig.imm     = ir[3:0];  end
      MOV_B_IMM: begin sig.b_we   = 1'b1; sig.imm     = ir[3:0];  end
      IN_A:      begin sig.a_we   = 1'b1; sig.src_sel = SRC_IN;   end
      IN_B:      begin sig.b_we   = 1'b1; sig.src_sel = SRC_IN;   end
      OUT_B:     begin sig.out_we = 1'b1; sig.src_sel = SRC_B;    end
      OUT_IMM:   begin sig.out_we = 1'b1; sig.imm     = ir[3:0];  end
      ADD_A_IMM: begin sig.a_we = 1'b1; sig.src_sel = SRC_A; sig.imm = ir[3:0]; end
      ADD_B_IMM: begin sig.b_we = 1'b1; sig.src_sel = SRC_B; sig.imm = ir[3:0]; end
      JMP_IMM: begin
        sig.imm     = ir[3:0];
        sig.ip_inc  = 1'b0;
        sig.ip_load = 1'b1;
      end
      JNC_IMM: begin
        // Branch taken only when no carry; otherwise fall through to IP+1.
        sig.imm     = ir[3:0];
        sig.ip_inc  = cf;
        sig.ip_load = ~cf;
      end
      default: begin
        sig     = '0;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: multi-cycle fetch/execute sequencer for the 4-bit CPU.
// Optional feature macro: CPU_CTRL_STEP_EN (single-step start from IDLE).
//   clk, rst_n              : clock, async active-low reset
//   run, step               : continuous-run level, single-step pulse
//   ip, cf                  : current IP and carry from the datapath
//   imem_req/addr/ack/data  : instruction fetch handshake
//   a_we,b_we,out_we,cf_we  : datapath write strobes (EXEC only)
//   src_sel, imm            : ALU source and addend
//   ip_inc, ip_load         : IP update strobes
//   retire                  : one valid instruction completed
//   halted, fetch_err       : sticky halt, and halt-by-timeout
module cpu_ctrl_seq
  import lib_cpu::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic [3:0] ip,
  input  logic       cf,
  output logic       imem_req,
  output logic [3:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic       a_we,
  output logic       b_we,
  output logic       out_we,
  output logic       cf_we,
  output logic [1:0] src_sel,
  output logic [3:0] imm,
  output logic       ip_inc,
  output logic       ip_load,
  output logic       retire,
  output logic       halted,
  output logic       fetch_err
);

  // Last FETCH cycle index allowed before declaring a timeout.
  localparam logic [3:0] CNT_LAST = 4'(FETCH_TIMEOUT - 1);

  CTRL_STATE  state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  CTRL_SIG    dec_sig;
  logic       dec_invalid;

  cpu_decoder u_dec (
    .ir      (ir_q),
    .cf      (cf),
    .sig     (dec_sig),
    .invalid (dec_invalid)
  );

  logic start_req;
`ifdef CPU_CTRL_STEP_EN
  assign start_req = run | step;
`else
  logic unused_step;
  assign unused_step = step;
  assign start_req   = run;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_req) state_d = FETCH;
      end
      FETCH: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (imem_ack) begin
          ir_d    = imem_data;
          cnt_d   = '0;
          state_d = EXEC;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      EXEC: begin
        if (dec_invalid)  state_d = HALT;
        else if (run)     state_d = FETCH;
        else              state_d = IDLE;
      end
      default: state_d = HALT;
    endcase
  end

  // Output decode
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = '0;
    a_we      = 1'b0;
    b_we      = 1'b0;
    out_we    = 1'b0;
    cf_we     = 1'b0;
    src_sel   = '0;
    imm       = '0;
    ip_inc    = 1'b0;
    ip_load   = 1'b0;
    retire    = 1'b0;
    halted    = (state_q == HALT);
    fetch_err = err_q;
    if (state_q == FETCH) begin
      imem_req  = 1'b1;
      imem_addr = ip;
    end
    if (state_q == EXEC && !dec_invalid) begin
      a_we    = dec_sig.a_we;
      b_we    = dec_sig.b_we;
      out_we  = dec_sig.out_we;
      cf_we   = dec_sig.cf_we;
      src_sel = dec_sig.src_sel;
      imm     = dec_sig.imm;
      ip_inc  = dec_sig.ip_inc;
      ip_load = dec_sig.ip_load;
      retire  = 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
module tb_cpu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n, run, step, cf, imem_ack;
  logic [3:0] ip;
  logic [7:0] imem_data;
  logic       imem_req, a_we, b_we, out_we, cf_we, ip_inc, ip_load;
  logic       retire, halted, fetch_err;
  logic [3:0] imem_addr, imm;
  logic [1:0] src_sel;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_ctrl_seq #(.FETCH_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .ip(ip), .cf(cf),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .a_we(a_we), .b_we(b_we), .out_we(out_we),
    .cf_we(cf_we), .src_sel(src_sel), .imm(imm), .ip_inc(ip_inc),
    .ip_load(ip_load), .retire(retire), .halted(halted), .fetch_err(fetch_err)
  );

  // Reference instruction table: destination (0=A 1=B 2=OUT 3=none),
  // ALU source (0=A 1=B 2=IN 3=ZERO), and whether imm carries IR[3:0].
  int dest_t [12] = '{0, 1, 0, 1, 0, 1, 2, 2, 0, 1, 3, 3};
  int src_t  [12] = '{1, 0, 3, 3, 2, 2, 1, 3, 0, 1, 3, 3};
  int immu_t [12] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};

  // {imem_req, a_we, b_we, out_we, cf_we, src_sel, imm, ip_inc, ip_load, retire}
  logic [13:0] exec_word;
  assign exec_word = {imem_req, a_we, b_we, out_we, cf_we, src_sel, imm,
                      ip_inc, ip_load, retire};
  logic [21:0] all_out;
  assign all_out = {exec_word, imem_addr, halted, fetch_err, 2'b00};

  function automatic logic [13:0] exp_exec(input logic [7:0] instr, input logic c);
    int op;
    logic [3:0] we;
    logic load;
    op = int'(instr[7:4]);
    if (op >= 12) return 14'h0;
    case (dest_t[op])
      0:       we = 4'b1001;
      1:       we = 4'b0101;
      2:       we = 4'b0011;
      default: we = 4'b0001;
    endcase
    load = (op == 10) || (op == 11 && !c);
    return {1'b0, we, 2'(src_t[op]), (immu_t[op] != 0) ? instr[3:0] : 4'h0,
            !load, load, 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered just before the first FETCH negedge. Ack arrives on fetch
  // cycle (delay+1); then the EXEC cycle is checked against the model.
  task automatic fetch_exec(input logic [7:0] instr, input int delay, input logic c,
                            input logic [3:0] ipv, input logic run_after,
                            input logic stp);
    ip = ipv;
    cf = c;
    for (int k = 0; k <= delay; k++) begin
      @(negedge clk);
      chk("fetch", {imem_req, imem_addr, a_we, b_we, out_we, retire, ip_inc, ip_load},
          {1'b1, ipv, 6'b0});
      if (k == 0) run = run_after;
      step      = stp && (k < delay);
      imem_ack  = (k == delay);
      imem_data = (k == delay) ? instr : 8'($urandom);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    step     = 1'b0;
    chk("exec", exec_word, exp_exec(instr, c));
  endtask

  task automatic expect_idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle", {imem_req, retire, halted}, 3'b000);
    end
  endtask

  initial begin
    logic [7:0] ins;
    rst_n = 1'b0; run = 1'b0; step = 1'b0; cf = 1'b0; imem_ack = 1'b0;
    ip = 4'h0; imem_data = 8'h00;

    @(negedge clk);
    chk("reset_outputs", all_out, 22'h0);
    rst_n = 1'b1;
    run   = 1'b1;

    // MOV_B_IMM 1 with ack on the first fetch cycle
    fetch_exec(8'h31, 0, 1'b0, 4'h0, 1'b1, 1'b0);
    // JNC_IMM 5, branch taken and not taken
    fetch_exec(8'hB5, 0, 1'b0, 4'h1, 1'b1, 1'b0);
    fetch_exec(8'hB5, 1, 1'b1, 4'h5, 1'b1, 1'b0);
    // ADD_A_IMM 15, ack delayed to fetch cycle 4 (the timeout limit): ack wins
    fetch_exec(8'h8F, 3, 1'b0, 4'h6, 1'b1, 1'b0);
    chk("ack_at_limit_no_err", {halted, fetch_err}, 2'b00);
    fetch_exec(8'hA3, 2, 1'b1, 4'hF, 1'b1, 1'b0);

    // Randomized valid instructions
    for (int i = 0; i < 40; i++) begin
      ins = {4'($urandom_range(0, 11)), 4'($urandom)};
      fetch_exec(ins, int'($urandom_range(0, 3)), 1'($urandom), 4'($urandom),
                 1'b1, 1'b0);
    end

    // run drops during FETCH: instruction completes, then IDLE
    fetch_exec(8'h64, 2, 1'b0, 4'h9, 1'b0, 1'b0);
    expect_idle(3);

`ifdef CPU_CTRL_STEP_EN
    step = 1'b1;
    fetch_exec(8'h2A, 2, 1'b0, 4'h3, 1'b0, 1'b1);
    expect_idle(4);
`else
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("step_ignored", {imem_req, retire}, 2'b00);
    expect_idle(3);
`endif

    // Reset asserted during EXEC kills the strobes immediately
    run = 1'b1;
    fetch_exec(8'h47, 0, 1'b0, 4'h2, 1'b1, 1'b0);
    @(negedge clk);
    imem_ack = 1'b1; imem_data = 8'h95;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("exec_before_abort", exec_word, exp_exec(8'h95, 1'b0));
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", all_out, 22'h0);

    // Fetch timeout: four FETCH cycles without ack
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    ip    = 4'h7;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("to_fetch", {imem_req, imem_addr, halted}, {1'b1, 4'h7, 1'b0});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("to_halt", {halted, fetch_err}, 2'b11);
      chk("to_no_strobes", exec_word, 14'h0);
    end
    rst_n = 1'b0;
    #1;
    chk("to_reset", all_out, 22'h0);

    // Invalid opcode halts without retiring
    @(negedge clk);
    rst_n = 1'b1;
    fetch_exec(8'hC0, 0, 1'b0, 4'h4, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      imem_ack = 1'b1; imem_data = 8'h31;
      chk("inv_halt", {halted, fetch_err, imem_req, retire}, 4'b1000);
    end
    imem_ack = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("inv_reset", all_out, 22'h0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch_exec(8'h7A, 1, 1'b1, 4'h8, 1'b0, 1'b0);
    expect_idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
